layer_stream_serializer: RTL and testbench
==========================================

# layer_stream_serializer

Parametrised successor to the inter-layer select stage in the streaming classifier. It captures a parallel layer-output bus on a `done_in` pulse and streams it out `LANES` neurons per beat to the next layer, using a valid/ready handshake. A two-slot ping-pong buffer lets the next layer result be captured while the previous one is still draining. The block sits between any hidden `layer` instance and the next layer's input port.

## Interface
- `DATA_WIDTH`, 12, width of one neuron value (signed, fixed point)
- `NEURONS`, 30, neurons in the captured layer
- `LANES`, 1, neuron values emitted per beat (1..NEURONS)
- `BEATS`, derived, ceil(NEURONS/LANES); not user-settable
- `clk` input 1, rising-edge clock
- `rst_n` input 1, asynchronous active-low reset
- `done_in` input 1, one-cycle pulse: `data_in` is valid this cycle
- `data_in` input NEURONS*DATA_WIDTH, neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `ready_in` input 1, downstream accepts the current beat
- `valid_out` output 1, `data_out` holds a valid beat
- `data_out` output LANES*DATA_WIDTH, lane j = neuron beat*LANES+j
- `lane_valid` output LANES, bit j set if lane j carries a real neuron
- `first_out` output 1, current beat is beat 0
- `last_out` output 1, current beat is beat BEATS-1
- `done_out` output 1, one-cycle pulse after the final beat of a slot is accepted
- `busy` output 1, at least one slot is occupied
- `overflow` output 1, sticky: a capture was dropped

## Operation
- Two slots, each NEURONS*DATA_WIDTH wide with a full flag. The write pointer and read pointer are each 1 bit. The beat counter runs 0..BEATS-1.
- FSM states:
  - IDLE: no slot full. `valid_out`=0.
  - STREAM: read slot full; `valid_out`=1.
  - IDLE->STREAM when a capture fills a slot.
  - STREAM->IDLE on acceptance of the last beat when the other slot is empty.
  - STREAM->STREAM (read pointer toggles, beat resets to 0) on acceptance of the last beat when the other slot is full.
- Capture rules:
  - `done_in` with a free slot: copy `data_in` into the slot at the write pointer, set its full flag, toggle the write pointer.
  - `done_in` with both slots full: drop the data and set `overflow`. Exception: if the last beat of the read slot is accepted in the same cycle, that slot counts as free and the capture succeeds.
- A beat is accepted when `valid_out && ready_in`. The beat counter increments on acceptance.
- While `valid_out && !ready_in`, `data_out`, `lane_valid`, `first_out` and `last_out` hold stable.
- Ragged last beat: lanes with index >= NEURONS-(BEATS-1)*LANES output zero and their `lane_valid` bit is clear. All other beats have `lane_valid` all ones.
- `overflow` clears only on reset.

## Timing
- Reset (async assert, sync release): slots empty, pointers 0, beat 0, state IDLE. All outputs are 0, including `overflow`.
- Latency: `done_in` at cycle t in IDLE gives `valid_out`=1 with beat 0 at t+1.
- Throughput with `ready_in` held high: one beat per cycle. There is no bubble between back-to-back slots.
- `done_out` is high in the cycle after last-beat acceptance, for exactly 1 cycle.
- Reset asserted mid-stream: stream aborted immediately, no `done_out`, both slots discarded.
- `data_out` is registered. No combinational path from `ready_in` or `done_in` to any output.

## Configuration
- `LAYER_SERIALIZER_RELU_EN` defined: a ReLU is applied at capture. Negative values (MSB=1) are stored as 0; non-negative values pass unchanged.
- Not defined: values are stored and streamed bit-exact. No ReLU logic is synthesised.

## Test plan
- NEURONS=5, LANES=2, DATA_WIDTH=12, ready_in=1; `done_in` with values 1,2,3,4,5.
  - Beats (1,2), (3,4), (5,0) at t+1..t+3.
  - `lane_valid` 11, 11, 01.
  - `first_out` on beat 0, `last_out` on beat 2, `done_out` at t+4.
- Backpressure: deassert `ready_in` for 3 cycles during beat 1 -> beat 1 held stable for all 3 cycles, then beat 2 follows; no beat lost or duplicated.
- Ping-pong: second `done_in` (10..50) during beat 0 of the first slot -> first frame's last beat is followed immediately by (10,20) with `first_out`=1; no idle cycle between them.
- Overflow: three `done_in` pulses while `ready_in`=0 -> `overflow`=1. First two frames stream intact once `ready_in`=1; third frame is absent.
- Simultaneous: both slots full, `done_in` in the same cycle as last-beat acceptance -> capture accepted, `overflow` stays 0.
- Reset mid-beat 1 -> all outputs 0 immediately; next `done_in` streams from beat 0. With RELU_EN: input -3 (0xFFD) is output as 0.

Source files
------------

// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer: captures a parallel layer result into a two-slot
// ping-pong buffer and streams it out LANES neurons per beat over valid/ready.
// Optional build macro LAYER_SERIALIZER_RELU_EN clamps negative neurons to
// zero at capture time; without it the values stream bit-exact.
module layer_stream_serializer #(
    parameter int DATA_WIDTH = 12,
    parameter int NEURONS    = 30,
    parameter int LANES      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          done_in,
    input  logic [NEURONS*DATA_WIDTH-1:0] data_in,
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic [LANES*DATA_WIDTH-1:0]   data_out,
    output logic [LANES-1:0]              lane_valid,
    output logic                          first_out,
    output logic                          last_out,
    output logic                          done_out,
    output logic                          busy,
    output logic                          overflow
);
    localparam int BEATS = (NEURONS + LANES - 1) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = NEURONS * DATA_WIDTH;
    localparam int PW    = BEATS * LANES * DATA_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      r_state, w_state_nxt;
    logic [SW-1:0]               r_slot [2];
    logic [1:0]                  r_full, w_full_nxt;
    logic                        r_wptr, r_rptr, w_rptr_nxt;
    logic [BW-1:0]               r_beat, w_beat_nxt;
    logic [LANES*DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [LANES-1:0]            r_lane, w_lane_nxt;
    logic                        r_first, r_last, r_done, r_busy, r_ovf;
    logic                        w_accept, w_last_acc, w_cap, w_drop, w_valid_nxt;
    logic [SW-1:0]               w_cap_data;
    logic [PW-1:0]               w_src;

`ifdef LAYER_SERIALIZER_RELU_EN
    for (genvar k = 0; k < NEURONS; k++) begin : g_relu
        assign w_cap_data[k*DATA_WIDTH +: DATA_WIDTH] =
            data_in[k*DATA_WIDTH+DATA_WIDTH-1] ? '0 : data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    assign w_cap_data = data_in;
`endif

    assign valid_out  = (r_state == STREAM);
    assign data_out   = r_data;
    assign lane_valid = r_lane;
    assign first_out  = r_first;
    assign last_out   = r_last;
    assign done_out   = r_done;
    assign busy       = r_busy;
    assign overflow   = r_ovf;

    // Slots fill in write-pointer order, so a full slot at the write pointer
    // means both are full; the last-beat acceptance frees exactly that slot.
    assign w_accept   = valid_out & ready_in;
    assign w_last_acc = w_accept & (r_beat == LAST_BEAT);
    assign w_cap      = done_in & (~r_full[r_wptr] | w_last_acc);
    assign w_drop     = done_in & ~w_cap;

    // Next slot occupancy, read pointer, beat counter and FSM state
    always_comb begin
        w_full_nxt = r_full;
        if (w_last_acc) w_full_nxt[r_rptr] = 1'b0;
        if (w_cap) w_full_nxt[r_wptr] = 1'b1;
        w_rptr_nxt  = r_rptr ^ w_last_acc;
        w_beat_nxt  = w_last_acc ? '0 : r_beat + BW'(w_accept);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cap) w_state_nxt = STREAM;
            STREAM:  if (w_last_acc && !w_full_nxt[w_rptr_nxt]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat to present next cycle; a slot captured this cycle is read from the input
    always_comb begin
        w_src = '0;
        w_src[SW-1:0] = (w_cap && r_wptr == w_rptr_nxt) ? w_cap_data : r_slot[w_rptr_nxt];
        w_valid_nxt = (w_state_nxt == STREAM);
        w_data_nxt  = '0;
        w_lane_nxt  = '0;
        for (int j = 0; j < LANES; j++) begin
            w_lane_nxt[j] = w_valid_nxt && (int'(w_beat_nxt) * LANES + j < NEURONS);
            w_data_nxt[j*DATA_WIDTH +: DATA_WIDTH] = w_valid_nxt ?
                w_src[(int'(w_beat_nxt) * LANES + j) * DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_full  <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_beat  <= '0;
            r_data  <= '0;
            r_lane  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            r_wptr  <= r_wptr ^ w_cap;
            r_rptr  <= w_rptr_nxt;
            r_beat  <= w_beat_nxt;
            r_data  <= w_data_nxt;
            r_lane  <= w_lane_nxt;
            r_first <= w_valid_nxt && (w_beat_nxt == '0);
            r_last  <= w_valid_nxt && (w_beat_nxt == LAST_BEAT);
            r_done  <= w_last_acc;
            r_busy  <= |w_full_nxt;
            r_ovf   <= r_ovf | w_drop;
        end
    end

    // Slot storage needs no reset: the full flags decide what is ever read
    always_ff @(posedge clk) begin
        if (w_cap) r_slot[r_wptr] <= w_cap_data;
    end
endmodule

// File: tb/tb_layer_stream_serializer.sv
// tb_layer_stream_serializer: directed and random checks of the serializer
// against a frame-queue reference model (honours LAYER_SERIALIZER_RELU_EN).
module tb_layer_stream_serializer;
    localparam int DW = 12;
    localparam int N  = 5;
    localparam int L  = 2;
    localparam int B  = (N + L - 1) / L;
    localparam int NW = N * DW;
    localparam int OW = L * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          done_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [NW-1:0] data_in = '0;
    logic          valid_out, first_out, last_out, done_out, busy, overflow;
    logic [OW-1:0] data_out;
    logic [L-1:0]  lane_valid;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [NW-1:0] mq[$];
    int            m_beat = 0;
    logic          m_ovf = 1'b0;
    logic          m_done = 1'b0;

    always #5 clk = ~clk;

    layer_stream_serializer #(.DATA_WIDTH(DW), .NEURONS(N), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .data_in(data_in),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .lane_valid(lane_valid), .first_out(first_out), .last_out(last_out),
        .done_out(done_out), .busy(busy), .overflow(overflow)
    );

    function automatic logic [NW-1:0] frame5(input int a, input int b, input int c, input int d, input int e);
        return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [NW-1:0] rnd_frame();
        logic [NW-1:0] f;
        for (int k = 0; k < N; k++) f[k*DW +: DW] = DW'($urandom_range(0, 4095));
        return f;
    endfunction

    function automatic logic [NW-1:0] relu(input logic [NW-1:0] f);
`ifdef LAYER_SERIALIZER_RELU_EN
        for (int k = 0; k < N; k++) if (f[k*DW+DW-1]) f[k*DW +: DW] = '0;
`endif
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic [OW-1:0] ed;
        logic [L-1:0]  el;
        logic [NW-1:0] fr;
        logic          v;
        int            idx;
        v  = mq.size() > 0;
        ed = '0;
        el = '0;
        if (v) begin
            fr = mq[0];
            for (int j = 0; j < L; j++) begin
                idx = m_beat * L + j;
                if (idx < N) begin
                    el[j] = 1'b1;
                    ed[j*DW +: DW] = fr[idx*DW +: DW];
                end
            end
        end
        chk({ctx, ".valid"}, valid_out, v);
        if (v) begin
            chk({ctx, ".data"}, data_out, ed);
            chk({ctx, ".lane"}, lane_valid, el);
        end
        chk({ctx, ".first"}, first_out, v && m_beat == 0);
        chk({ctx, ".last"}, last_out, v && m_beat == B - 1);
        chk({ctx, ".done"}, done_out, m_done);
        chk({ctx, ".busy"}, busy, v);
        chk({ctx, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic model(input logic d, input logic [NW-1:0] din, input logic r);
        m_done = 1'b0;
        if (mq.size() > 0 && r) begin
            if (m_beat == B - 1) begin
                void'(mq.pop_front());
                m_beat = 0;
                m_done = 1'b1;
            end else m_beat++;
        end
        if (d) begin
            if (mq.size() < 2) mq.push_back(relu(din));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic d, input logic [NW-1:0] din, input logic r, input string ctx);
        done_in  = d;
        data_in  = din;
        ready_in = r;
        model(d, din, r);
        @(posedge clk);
        @(negedge clk);
        done_in = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic check_all_zero(input string ctx);
        chk({ctx, ".valid"}, valid_out, 0);
        chk({ctx, ".data"}, data_out, 0);
        chk({ctx, ".lane"}, lane_valid, 0);
        chk({ctx, ".first"}, first_out, 0);
        chk({ctx, ".last"}, last_out, 0);
        chk({ctx, ".done"}, done_out, 0);
        chk({ctx, ".busy"}, busy, 0);
        chk({ctx, ".ovf"}, overflow, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        step(1'b1, frame5(1, 2, 3, 4, 5), 1'b1, "basic.b0");
        chk("basic.b0.lit", data_out, {12'd2, 12'd1});
        chk("basic.b0.lanelit", lane_valid, 2'b11);
        step(1'b0, '0, 1'b1, "basic.b1");
        chk("basic.b1.lit", data_out, {12'd4, 12'd3});
        step(1'b0, '0, 1'b1, "basic.b2");
        chk("basic.b2.lit", data_out, {12'd0, 12'd5});
        chk("basic.b2.lanelit", lane_valid, 2'b01);
        chk("basic.b2.lastlit", last_out, 1);
        step(1'b0, '0, 1'b1, "basic.done");
        chk("basic.donelit", done_out, 1);
        step(1'b0, '0, 1'b1, "basic.idle");

        step(1'b1, rnd_frame(), 1'b1, "bp.b0");
        step(1'b0, '0, 1'b1, "bp.b1");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "bp.hold");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "bp.drain");

        step(1'b1, frame5(1, 2, 3, 4, 5), 1'b1, "pp.a0");
        step(1'b1, frame5(10, 20, 30, 40, 50), 1'b1, "pp.a1");
        step(1'b0, '0, 1'b1, "pp.a2");
        step(1'b0, '0, 1'b1, "pp.b0");
        chk("pp.b0.lit", data_out, {12'd20, 12'd10});
        chk("pp.b0.firstlit", first_out, 1);
        chk("pp.b0.donelit", done_out, 1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "pp.drain");

        step(1'b1, rnd_frame(), 1'b0, "sim.fill0");
        step(1'b1, rnd_frame(), 1'b0, "sim.fill1");
        step(1'b0, '0, 1'b1, "sim.b1");
        step(1'b0, '0, 1'b1, "sim.b2");
        step(1'b1, rnd_frame(), 1'b1, "sim.cap");
        chk("sim.ovflit", overflow, 0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, "sim.drain");

        for (int i = 0; i < 3; i++) step(1'b1, rnd_frame(), 1'b0, "ovf.fill");
        chk("ovf.lit", overflow, 1);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, "ovf.drain");

        step(1'b1, rnd_frame(), 1'b1, "rst.b0");
        step(1'b0, '0, 1'b1, "rst.b1");
        rst_n = 1'b0;
        #1 check_all_zero("rst.async");
        mq.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, frame5(4093, 7, 2048, 1, 2047), 1'b1, "relu.b0");
`ifdef LAYER_SERIALIZER_RELU_EN
        chk("relu.lane0", data_out[DW-1:0], 0);
`else
        chk("relu.lane0", data_out[DW-1:0], 12'hFFD);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "relu.drain");

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, rnd_frame(), $urandom_range(0, 3) != 0, "rnd");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "rnd.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
